// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// Holds the FSM state encoding and the len_i-to-effective-length mapping.
package serial_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_t;

    // A len_i of zero selects the full word width, so every length from 1 to WIDTH fits in LW bits.
    localparam bit LEN_ZERO_MEANS_MAX = 1'b1;

    function automatic int eff_len(input int len, input int width);
        return (len == 0 && LEN_ZERO_MEANS_MAX) ? width : len;
    endfunction

endpackage

// File: rtl/serial_pattern_tx_piso.sv
// Parallel-in serial-out shift register, MSB leaves first.
// Load wins over shift; vacated LSBs fill with zero.
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = load_data_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial pattern transmitter: sends len bits MSB-first, then idles GAP cycles.
// All line outputs are registered; ready_o decodes the state only.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   GAP        = 1,
    parameter logic IDLE_LEVEL = 1'b0,
    localparam int  LW         = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [LW-1:0]    len_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             out_o,
    output logic             active_o,
    output logic             done_o
);

    localparam int CW       = $clog2(WIDTH + 1);
    localparam int GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

    tx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             out_q, out_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    logic [CW-1:0]    len_eff;
    logic [CW-1:0]    shift_amt;
    logic [WIDTH-1:0] aligned;
    logic             sr_load;
    logic             sr_shift;
    logic             sr_msb;

    // Left-justify the pattern so its first bit sits in the MSB.
    assign len_eff   = CW'(eff_len(int'(len_i), WIDTH));
    assign shift_amt = CW'(WIDTH) - len_eff;
    assign aligned   = data_i << shift_amt;

    // The first bit goes straight to out_q at the handshake, so the register holds the rest.
    piso_shreg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (sr_load),
        .shift_i     (sr_shift),
        .load_data_i (aligned << 1),
        .msb_o       (sr_msb)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        out_d    = IDLE_LEVEL;
        active_d = 1'b0;
        done_d   = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    sr_load  = 1'b1;
                    out_d    = aligned[WIDTH-1];
                    active_d = 1'b1;
                    done_d   = (len_eff == CW'(1));
                    cnt_d    = len_eff - CW'(1);
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // cnt_q counts bits still to send after the one now on the line.
                if (cnt_q != '0) begin
                    sr_shift = 1'b1;
                    out_d    = sr_msb;
                    active_d = 1'b1;
                    done_d   = (cnt_q == CW'(1));
                    cnt_d    = cnt_q - CW'(1);
                end else begin
                    gap_d   = GW'(GAP_LOAD);
                    state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            out_q    <= IDLE_LEVEL;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            out_q    <= out_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign out_o    = out_q;
    assign active_o = active_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: three parameterisations plus a 1011 Mealy detector on the line.
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic [2:0] len;
    logic       valid_a, valid_b, valid_c;
    logic       ready_a, out_a, active_a, done_a;
    logic       ready_b, out_b, active_b, done_b;
    logic       ready_c, out_c, active_c, done_c;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(8), .GAP(1), .IDLE_LEVEL(1'b0)) u_a (
        .clk_i(clk), .reset_i(reset), .data_i(data), .len_i(len), .valid_i(valid_a),
        .ready_o(ready_a), .out_o(out_a), .active_o(active_a), .done_o(done_a)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(0), .IDLE_LEVEL(1'b0)) u_b (
        .clk_i(clk), .reset_i(reset), .data_i(data), .len_i(len), .valid_i(valid_b),
        .ready_o(ready_b), .out_o(out_b), .active_o(active_b), .done_o(done_b)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(3), .IDLE_LEVEL(1'b1)) u_c (
        .clk_i(clk), .reset_i(reset), .data_i(data), .len_i(len), .valid_i(valid_c),
        .ready_o(ready_c), .out_o(out_c), .active_o(active_c), .done_o(done_c)
    );

    // Overlapping "1011" Mealy detector fed from instance a's serial line.
    logic [1:0] det_st;
    logic       det_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            det_st <= 2'd0;
        end else begin
            case (det_st)
                2'd0:    det_st <= out_a ? 2'd1 : 2'd0;
                2'd1:    det_st <= out_a ? 2'd1 : 2'd2;
                2'd2:    det_st <= out_a ? 2'd3 : 2'd0;
                default: det_st <= out_a ? 2'd1 : 2'd2;
            endcase
        end
    end

    assign det_out = (det_st == 2'd3) && out_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Sends one pattern on instance a; seq and det hold the expected line bits and detector hits, MSB first.
    task automatic run_a(input string tag, input logic [7:0] d, input logic [2:0] l,
                         input int n, input logic [7:0] seq, input logic [7:0] det);
        data    = d;
        len     = l;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        data    = ~d;
        len     = l + 3'd1;
        $display("tx %s: data=%02h len=%0d", tag, d, l);
        for (int k = 0; k < n; k++) begin
            chk({tag, "/out"},    32'(out_a),    32'(seq[7-k]));
            chk({tag, "/active"}, 32'(active_a), 32'd1);
            chk({tag, "/done"},   32'(done_a),   32'(k == n - 1));
            chk({tag, "/ready"},  32'(ready_a),  32'd0);
            chk({tag, "/det"},    32'(det_out),  32'(det[7-k]));
            step();
        end
        chk({tag, "/gap_out"},    32'(out_a),    32'd0);
        chk({tag, "/gap_active"}, 32'(active_a), 32'd0);
        chk({tag, "/gap_done"},   32'(done_a),   32'd0);
        chk({tag, "/gap_ready"},  32'(ready_a),  32'd0);
        step();
        chk({tag, "/idle_ready"}, 32'(ready_a),  32'd1);
        chk({tag, "/idle_out"},   32'(out_a),    32'd0);
    endtask

    initial begin
        logic [0:9] b_out, b_rdy, b_act, b_done;
        logic [0:8] c_out, c_rdy, c_act;

        reset   = 1'b1;
        data    = 8'h00;
        len     = 3'd0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;
        step();
        step();
        chk("rst/a_ready",  32'(ready_a),  32'd1);
        chk("rst/a_out",    32'(out_a),    32'd0);
        chk("rst/a_active", 32'(active_a), 32'd0);
        chk("rst/a_done",   32'(done_a),   32'd0);
        chk("rst/b_ready",  32'(ready_b),  32'd1);
        chk("rst/c_out",    32'(out_c),    32'd1);
        chk("rst/c_ready",  32'(ready_c),  32'd1);
        reset = 1'b0;
        step();

        run_a("basic", 8'hB2, 3'd0, 8, 8'b1011_0010, 8'b0001_0000);
        run_a("short", 8'hF5, 3'd3, 3, 8'b1010_0000, 8'b0000_0000);

        // GAP=0 with valid held: 4-bit 1101, one idle cycle, then 4-bit 1010.
        b_out  = 10'b1101_0_1010_0;
        b_rdy  = 10'b0000_1_0000_1;
        b_act  = 10'b1111_0_1111_0;
        b_done = 10'b0001_0_0001_0;
        data    = 8'h0D;
        len     = 3'd4;
        valid_b = 1'b1;
        step();
        $display("tx b2b: data=0d then 0a len=4");
        for (int i = 0; i < 10; i++) begin
            if (i == 1) data = 8'h0A;
            if (i == 5) valid_b = 1'b0;
            chk("b2b/out",    32'(out_b),    32'(b_out[i]));
            chk("b2b/ready",  32'(ready_b),  32'(b_rdy[i]));
            chk("b2b/active", 32'(active_b), 32'(b_act[i]));
            chk("b2b/done",   32'(done_b),   32'(b_done[i]));
            step();
        end

        // Reset while the 4th bit of 1011_0010 is on the line.
        data    = 8'hB2;
        len     = 3'd0;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        $display("tx rst_mid: data=b2 len=0");
        chk("rst_mid/bit1", 32'(out_a), 32'd1);
        step();
        chk("rst_mid/bit2", 32'(out_a), 32'd0);
        step();
        chk("rst_mid/bit3", 32'(out_a), 32'd1);
        step();
        chk("rst_mid/bit4", 32'(out_a), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid/out",    32'(out_a),    32'd0);
        chk("rst_mid/active", 32'(active_a), 32'd0);
        chk("rst_mid/ready",  32'(ready_a),  32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid/done", 32'(done_a), 32'd0);
            step();
        end

        // A handshake coinciding with reset must be dropped.
        data    = 8'hFF;
        valid_a = 1'b1;
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        valid_a = 1'b0;
        $display("tx rst_hs: data=ff dropped");
        chk("rst_hs/active", 32'(active_a), 32'd0);
        chk("rst_hs/ready",  32'(ready_a),  32'd1);
        step();
        chk("rst_hs/active2", 32'(active_a), 32'd0);

        run_a("after_rst", 8'h3C, 3'd6, 6, 8'b1111_0000, 8'b0000_0000);

        // IDLE_LEVEL=1, GAP=3: two 2-bit zero patterns separated by 3 gap cycles and 1 idle cycle.
        c_out = 9'b00_1111_00_1;
        c_rdy = 9'b00_0001_00_0;
        c_act = 9'b11_0000_11_0;
        data    = 8'h00;
        len     = 3'd2;
        valid_c = 1'b1;
        step();
        $display("tx gap3: data=00 len=2 twice");
        for (int i = 0; i < 9; i++) begin
            if (i == 6) valid_c = 1'b0;
            chk("gap3/out",    32'(out_c),    32'(c_out[i]));
            chk("gap3/ready",  32'(ready_c),  32'(c_rdy[i]));
            chk("gap3/active", 32'(active_c), 32'(c_act[i]));
            step();
        end

        run_a("detect", 8'h0B, 3'd4, 4, 8'b1011_0000, 8'b0001_0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
